sm_reg_dump: RTL and testbench

Register-file dump engine: on a start pulse it walks CPU register addresses 0..31 over the debug read port (regAddr/regData) and streams each value as an uppercase ASCII hex line on a UART 8N1 transmit pin. It is the initiator side of the register readout interface, replacing the board switches and display that normally drive regAddr. It sits in the board top, drives the CPU's regAddr input and consumes regData.

---
 rtl/sm_reg_dump_pkg.sv | 32 +++
 rtl/sm_uart_tx.sv | 82 ++++++++
 rtl/sm_reg_dump.sv | 184 ++++++++++++++++++
 tb/tb_sm_reg_dump.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_reg_dump_pkg.sv
// ============================================================================
// sm_reg_dump_pkg -- shared FSM encoding, ASCII constants and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package sm_reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_NEXT    = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Line lengths include the trailing LF; the prefixed form adds "AA:".
  localparam int LINE_LEN_PLAIN    = 9;
  localparam int LINE_LEN_PREFIX   = 12;
  localparam int CHAR_IDX_W_PLAIN  = 4;
  localparam int CHAR_IDX_W_PREFIX = 4;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    nibble_to_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_uart_tx.sv
// ============================================================================
// sm_uart_tx -- 8N1 byte transmitter with valid/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module sm_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic        active_q, active_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        frame_end;

  assign bit_end   = active_q && (baud_q == BAUD_LAST);
  assign frame_end = bit_end && (bit_q == 4'd9);
  // Ready in the last stop-bit cycle lets the next frame follow with no gap.
  assign ready     = !active_q || frame_end;
  assign tx        = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
    if (valid && ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
      shift_d  = {1'b1, data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm_reg_dump.sv
// ============================================================================
// sm_reg_dump -- walks registers 0..31 and streams each as an ASCII hex line
// Option macro: SM_REG_DUMP_ADDR_PREFIX_EN adds an "AA:" address prefix.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sm_reg_dump
  import sm_reg_dump_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int SETTLE   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] regData,
  output logic [4:0]  regAddr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
  localparam int LINE_LEN = LINE_LEN_PREFIX;
  localparam int IDX_W    = CHAR_IDX_W_PREFIX;
`else
  localparam int LINE_LEN = LINE_LEN_PLAIN;
  localparam int IDX_W    = CHAR_IDX_W_PLAIN;
`endif

  localparam logic [IDX_W-1:0] IDX_END     = IDX_W'(LINE_LEN);
  localparam logic [IDX_W-1:0] IDX_LF      = IDX_W'(LINE_LEN - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [4:0]       addr_q, addr_d;
  logic [3:0]       settle_q, settle_d;
  logic [31:0]      hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       char_data;
  logic [31:0]      char_word;
  logic [31:0]      char_shift;
  logic [IDX_W-1:0] char_idx;

  // During CAPTURE the first character is taken straight from regData.
  assign char_word = (state_q == ST_CAPTURE) ? regData : hold_q;
  assign char_idx  = (state_q == ST_CAPTURE) ? '0 : idx_q;
  assign tx_valid  = (state_q == ST_CAPTURE) ||
                     ((state_q == ST_SEND) && (idx_q != IDX_END));

`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
  logic [4:0]       line_addr_q, line_addr_d;
  logic [4:0]       char_addr;
  logic [IDX_W-1:0] nib_idx;

  assign char_addr = (state_q == ST_CAPTURE) ? addr_q : line_addr_q;

  always_comb begin
    nib_idx    = char_idx - IDX_W'(3);
    char_shift = char_word << {nib_idx[2:0], 2'b00};
    case (char_idx)
      IDX_W'(0): char_data = nibble_to_ascii({3'b000, char_addr[4]});
      IDX_W'(1): char_data = nibble_to_ascii(char_addr[3:0]);
      IDX_W'(2): char_data = ASCII_COLON;
      IDX_LF:    char_data = ASCII_LF;
      default:   char_data = nibble_to_ascii(char_shift[31:28]);
    endcase
  end
`else
  always_comb begin
    char_shift = char_word << {char_idx[2:0], 2'b00};
    char_data  = (char_idx == IDX_LF) ? ASCII_LF : nibble_to_ascii(char_shift[31:28]);
  end
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    settle_d = settle_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
    line_addr_d = line_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CAPTURE;
        else                         settle_d = settle_q + 4'd1;
      end
      ST_CAPTURE: begin
        hold_d  = regData;
        idx_d   = tx_ready ? IDX_W'(1) : '0;
        state_d = ST_SEND;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
        line_addr_d = addr_q;
`endif
      end
      ST_SEND: begin
        // With every character handed over, ready next marks the LF stop bit end.
        if (idx_q == IDX_END) begin
          if (tx_ready) begin
            state_d = ST_NEXT;
            if (addr_q == 5'd31) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end
        end else if (tx_ready) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_NEXT: begin
        if (addr_q != 5'd31) begin
          addr_d   = addr_q + 5'd1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      settle_q <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
      line_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
      line_addr_q <= line_addr_d;
`endif
    end
  end

  sm_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (char_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

  assign regAddr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_reg_dump.sv
// ============================================================================
// tb_sm_reg_dump -- cycle timeline model plus UART line decoder for sm_reg_dump
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sm_reg_dump;

  localparam int BD   = 4;
  localparam int ST   = 3;
  localparam int MAXC = 16384;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
  localparam int NCH = 12;
`else
  localparam int NCH = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic        tx, busy, done;
  int          mode = 0;

  assign reg_data = (mode == 0) ? 32'hDEADBEEF : {27'b0, reg_addr};

  always #5 clk = ~clk;

  sm_reg_dump #(.BAUD_DIV(BD), .SETTLE(ST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .regData (reg_data),
    .regAddr (reg_addr),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  int total = 0;
  int bad   = 0;

  // Expected per-cycle timeline of one dump, indexed from the start cycle.
  logic       exp_tx   [MAXC];
  logic       exp_busy [MAXC];
  logic       exp_done [MAXC];
  logic [4:0] exp_addr [MAXC];
  int         exp_len;
  int         line_b [32];
  logic [7:0] exp_bytes [$];

  int  cyc = 0;
  int  t0 = 0;
  bit  mdl_on = 0;
  bit  diverged = 0;

  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_bytes [$];
  int         falls [$];
  int         fr_err = 0;
  int         done_cnt = 0;
  int         busy_bad = 0;
  logic [4:0] addr_seq [$];

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'd48 + {4'd0, n}) : (8'd55 + {4'd0, n});
  endfunction

  task automatic set_exp(input int t, input logic a, input logic b, input logic c, input logic [4:0] ad);
    exp_tx[t] = a; exp_busy[t] = b; exp_done[t] = c; exp_addr[t] = ad;
  endtask

  task automatic build_model(input int md, input logic [4:0] a0);
    int t;
    logic [31:0] d;
    logic [7:0] ln [$];
    logic [7:0] ch;
    exp_bytes.delete();
    set_exp(0, 1'b1, 1'b0, 1'b0, a0);
    t = 1;
    for (int l = 0; l < 32; l++) begin
      d = (md == 0) ? 32'hDEADBEEF : 32'(l);
      ln.delete();
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
      ln.push_back(hexc(4'(l >> 4)));
      ln.push_back(hexc(4'(l)));
      ln.push_back(8'h3A);
`endif
      for (int j = 7; j >= 0; j--) ln.push_back(hexc(d[j*4 +: 4]));
      ln.push_back(8'h0A);
      line_b[l] = t;
      for (int k = 0; k <= ST; k++) begin set_exp(t, 1'b1, 1'b1, 1'b0, 5'(l)); t++; end
      foreach (ln[j]) begin
        ch = ln[j];
        exp_bytes.push_back(ch);
        for (int k = 0; k < 10; k++)
          for (int r = 0; r < BD; r++) begin
            set_exp(t, (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : ch[k-1], 1'b1, 1'b0, 5'(l));
            t++;
          end
      end
      set_exp(t, 1'b1, (l != 31), (l == 31), 5'(l));
      t++;
    end
    set_exp(t, 1'b1, 1'b0, 1'b0, 5'd31);
    exp_len = t + 1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_str(input string nm, input string got, input string want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", nm, got, want);
    end
  endtask

  function automatic string bytes_str(input int from, input int n);
    string s = "";
    for (int i = 0; i < n; i++)
      if (from + i < rx_bytes.size()) begin
        if (rx_bytes[from+i] == 8'h0A) s = {s, "\\n"};
        else s = {s, $sformatf("%c", rx_bytes[from+i])};
      end
    return s;
  endfunction

  function automatic int byte_mism(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (i >= rx_bytes.size() || i >= exp_bytes.size() || rx_bytes[i] !== exp_bytes[i]) c++;
    return c;
  endfunction

  task automatic monitor();
    int t;
    int k;
    if (mdl_on && !diverged && rst_n) begin
      t = cyc - t0;
      if (t < exp_len) begin
        total++;
        if ({tx, busy, done, reg_addr} !== {exp_tx[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
          bad++;
          diverged = 1;
          $display("FAIL timeline t=%0d: got tx=%b busy=%b done=%b addr=%0d want tx=%b busy=%b done=%b addr=%0d",
                   t, tx, busy, done, reg_addr, exp_tx[t], exp_busy[t], exp_done[t], exp_addr[t]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) busy_bad++;
    end
    if (busy === 1'b1 && (addr_seq.size() == 0 || addr_seq[$] != reg_addr)) addr_seq.push_back(reg_addr);
    if (!rst_n) begin
      rx_cnt = 0;
    end else if (rx_cnt == 0) begin
      if (tx === 1'b0) begin
        falls.push_back(cyc);
        rx_cnt = 1;
      end
    end else begin
      if (rx_cnt % BD == BD / 2) begin
        k = rx_cnt / BD;
        if (k >= 1 && k <= 8) rx_sh[k-1] = tx;
        if (k == 9 && tx !== 1'b1) fr_err++;
      end
      if (rx_cnt == 10 * BD - 1) begin
        rx_bytes.push_back(rx_sh);
        rx_cnt = 0;
      end else begin
        rx_cnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic start_dump(input int md, input logic [4:0] a0);
    mode = md;
    build_model(md, a0);
    rx_bytes.delete();
    falls.delete();
    addr_seq.delete();
    done_cnt = 0;
    busy_bad = 0;
    fr_err   = 0;
    diverged = 0;
    t0       = cyc;
    mdl_on   = 1;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (cyc - t0 < t) step();
  endtask

  initial begin
    int lows;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", reg_addr, 0);
    rst_n = 1'b1;

    lows = 0;
    repeat (1000) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("idle_no_activity", lows, 0);

    // DEADBEEF dump, cut by reset during data bit 0 of line 7
    start_dump(0, 5'd0);
    run_to(line_b[7] + ST + 1 + BD + 1);
    check("tx_before_reset", tx, 0);
    rst_n = 1'b0;
    #1;
    mdl_on = 0;
    check("tx_at_reset_edge", tx, 1);
    check("busy_at_reset", busy, 0);
    check("done_at_reset", done, 0);
    check("addr_at_reset", reg_addr, 0);
    check("first_fall_cycle", (falls.size() > 0) ? 32'(falls[0] - t0) : 32'hFFFF_FFFF, 5);
    check("frame_len", (falls.size() > 1) ? 32'(falls[1] - falls[0]) : 32'hFFFF_FFFF, 40);
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
    check_str("line0_deadbeef", bytes_str(0, NCH), "00:DEADBEEF\\n");
`else
    check_str("line0_deadbeef", bytes_str(0, NCH), "DEADBEEF\\n");
`endif
    check("bytes_before_reset", rx_bytes.size(), 7 * NCH);
    check("deadbeef_byte_mismatches", byte_mism(7 * NCH), 0);
    check("deadbeef_done_count", done_cnt, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Full identity dump restarted after the reset
    start_dump(1, 5'd0);
    run_to(exp_len);
    check("id_byte_count", rx_bytes.size(), 32 * NCH);
    check("id_byte_mismatches", byte_mism(32 * NCH), 0);
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
    check_str("id_first_line", bytes_str(0, NCH), "00:00000000\\n");
    check_str("id_last_line", bytes_str(31 * NCH, NCH), "1F:0000001F\\n");
`else
    check_str("id_first_line", bytes_str(0, NCH), "00000000\\n");
    check_str("id_last_line", bytes_str(31 * NCH, NCH), "0000001F\\n");
`endif
    check("id_done_count", done_cnt, 1);
    check("id_busy_with_done", busy_bad, 0);
    check("id_frame_errors", fr_err, 0);
    check("id_addr_seq_len", addr_seq.size(), 32);
    lows = 0;
    foreach (addr_seq[i]) if (addr_seq[i] != 5'(i)) lows++;
    check("id_addr_seq_order", lows, 0);

    // Start pulses during lines 3 and 20 must be ignored
    start_dump(1, 5'd31);
    run_to(line_b[3] + 60);
    start = 1'b1; step(); start = 1'b0;
    run_to(line_b[20] + 100);
    start = 1'b1; step(); start = 1'b0;
    run_to(exp_len);
    check("busy_start_byte_count", rx_bytes.size(), 32 * NCH);
    check("busy_start_byte_mismatches", byte_mism(32 * NCH), 0);
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_busy_with_done", busy_bad, 0);
    repeat (20) step();
    check("after_dump_done_count", done_cnt, 1);
    check("after_dump_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
